bmp_stream_sched: RTL and testbench

BMP_STREAM_SCHED -- requirements
Module: bmp_stream_sched

---
 rtl/bmp_stream_sched.sv | 273 +++++++++++++++++++++++++++
 tb/tb_bmp_stream_sched.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bmp_stream_sched.sv
// BMP stream scheduler: round-robin grant of one slave per file, header capture,
// process/bypass body routing and a first-word-fall-through output FIFO.
// Optional stall timeout is enabled with the SCHED_TIMEOUT_EN macro.
module bmp_stream_sched #(
    parameter int DATA_BUS_SIZE  = 32,
    parameter int NUM_SLV        = 2,
    parameter int FIFO_DEPTH     = 8,
    parameter int HDR_BYTES      = 56,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_SLV-1:0]               slv_valid,
    input  logic [2*NUM_SLV-1:0]             slv_mode,
    input  logic [NUM_SLV*DATA_BUS_SIZE-1:0] slv_data,
    output logic [NUM_SLV-1:0]               slv_ready,
    output logic [DATA_BUS_SIZE-1:0]         proc_data,
    output logic                             proc_vld,
    input  logic                             proc_rdy,
    input  logic [DATA_BUS_SIZE-1:0]         proc_res_data,
    input  logic                             proc_res_vld,
    input  logic                             mstr_ready,
    output logic [DATA_BUS_SIZE-1:0]         mstr_data,
    output logic                             mstr_valid,
    output logic                             mstr_cmplt,
    output logic [$clog2(NUM_SLV)-1:0]       grant_id,
    output logic [31:0]                      file_size,
    output logic                             err
);

    localparam int BPW = DATA_BUS_SIZE / 8;
    localparam int GW  = $clog2(NUM_SLV);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int CS  = CW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CS-1:0] DEPTH_S = CS'(FIFO_DEPTH);
    localparam logic [32:0]   BPW_S   = 33'(BPW);
    localparam logic [32:0]   HDR_S   = 33'(HDR_BYTES);
    localparam logic [31:0]   HDR_C   = 32'(HDR_BYTES);
    localparam logic [GW-1:0] LAST_ID = GW'(NUM_SLV - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_BODY, ST_FLUSH} state_t;

    state_t                   state_reg;
    logic [GW-1:0]            grant_id_reg;
    logic [GW-1:0]            rr_ptr_reg;
    logic                     mode_proc_reg;
    logic [31:0]              byte_cnt_reg;
    logic [31:0]              file_size_reg;
    logic [CW-1:0]            outstanding_reg;
    logic [CW-1:0]            fifo_count_reg;
    logic [AW-1:0]            wr_ptr_reg;
    logic [AW-1:0]            rd_ptr_reg;
    logic                     err_reg;
    logic                     cmplt_reg;
    logic [DATA_BUS_SIZE-1:0] fifo_mem [FIFO_DEPTH];

    logic [DATA_BUS_SIZE-1:0] slv_word [NUM_SLV];
    logic [1:0]               slv_mode_arr [NUM_SLV];
    logic [NUM_SLV-1:0]       elig;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLV; gi++) begin : g_slv
            assign slv_word[gi]     = slv_data[gi*DATA_BUS_SIZE +: DATA_BUS_SIZE];
            assign slv_mode_arr[gi] = slv_mode[2*gi +: 2];
            assign elig[gi]         = slv_valid[gi] &&
                                      (slv_mode[2*gi +: 2] == 2'b01 || slv_mode[2*gi +: 2] == 2'b10);
        end
    endgenerate

    // Round-robin search beginning at rr_ptr
    logic          pick_found;
    logic [GW-1:0] pick_id;
    int            pick_idx;
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        pick_idx   = 0;
        for (int i = 0; i < NUM_SLV; i++) begin
            pick_idx = int'(rr_ptr_reg) + i;
            if (pick_idx >= NUM_SLV) pick_idx = pick_idx - NUM_SLV;
            if (!pick_found && elig[pick_idx]) begin
                pick_found = 1'b1;
                pick_id    = GW'(pick_idx);
            end
        end
    end
    logic pick_mode_proc;
    assign pick_mode_proc = (slv_mode_arr[pick_id] == 2'b01);

    logic                     g_valid;
    logic [DATA_BUS_SIZE-1:0] g_data;
    logic                     fifo_full, fifo_empty, credit_ok, in_xfer, in_proc_body;
    logic                     g_ready, accept, issue, res_ok, res_drop;
    logic                     push_en, push_ok, pop;
    logic [DATA_BUS_SIZE-1:0] push_data;
    logic                     stall_hit;

    assign g_valid      = slv_valid[grant_id_reg];
    assign g_data       = slv_word[grant_id_reg];
    assign fifo_full    = (fifo_count_reg == DEPTH_C);
    assign fifo_empty   = (fifo_count_reg == '0);
    assign credit_ok    = ({1'b0, fifo_count_reg} + {1'b0, outstanding_reg}) < DEPTH_S;
    assign in_xfer      = (state_reg == ST_HDR) || (state_reg == ST_BODY);
    assign in_proc_body = (state_reg == ST_BODY) && mode_proc_reg;

    always_comb begin
        g_ready = 1'b0;
        if (state_reg == ST_HDR)
            g_ready = !fifo_full;
        else if (state_reg == ST_BODY)
            g_ready = mode_proc_reg ? (proc_rdy && credit_ok) : !fifo_full;
    end

    generate
        for (gi = 0; gi < NUM_SLV; gi++) begin : g_ready_fan
            assign slv_ready[gi] = g_ready && (grant_id_reg == GW'(gi));
        end
    endgenerate

    assign accept    = g_valid && g_ready;
    assign issue     = accept && in_proc_body;
    assign proc_vld  = in_proc_body && g_valid && credit_ok;
    assign proc_data = in_proc_body ? g_data : '0;

    // Results are only meaningful while a process-mode file is in its body or draining
    assign res_ok    = proc_res_vld && mode_proc_reg &&
                       ((state_reg == ST_BODY) || (state_reg == ST_FLUSH));
    assign res_drop  = proc_res_vld && !res_ok;

    assign push_en   = (accept && !issue) || res_ok;
    assign push_data = res_ok ? proc_res_data : g_data;
    assign pop       = !fifo_empty && mstr_ready;
    assign push_ok   = push_en && (!fifo_full || pop);

    // Byte counter and file-size capture from header bytes 2..5
    logic [32:0] byte_sum;
    logic [31:0] fs_next;
    logic [31:0] gb;
    assign byte_sum = {1'b0, byte_cnt_reg} + BPW_S;
    always_comb begin
        fs_next = file_size_reg;
        gb      = '0;
        for (int k = 0; k < BPW; k++) begin
            gb = byte_cnt_reg + 32'(k);
            case (gb)
                32'd2:   fs_next[7:0]   = g_data[8*k +: 8];
                32'd3:   fs_next[15:8]  = g_data[8*k +: 8];
                32'd4:   fs_next[23:16] = g_data[8*k +: 8];
                32'd5:   fs_next[31:24] = g_data[8*k +: 8];
                default: ;
            endcase
        end
    end

`ifdef SCHED_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STALL_LIM = SW'(TIMEOUT_CYCLES - 1);
    logic [SW-1:0] stall_cnt_reg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_reg <= '0;
        else if (!in_xfer || accept || stall_hit)
            stall_cnt_reg <= '0;
        else if (!g_valid)
            stall_cnt_reg <= stall_cnt_reg + SW'(1);
    end
    assign stall_hit = in_xfer && !g_valid && (stall_cnt_reg == STALL_LIM);
`else
    assign stall_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            grant_id_reg  <= '0;
            rr_ptr_reg    <= '0;
            mode_proc_reg <= 1'b0;
            byte_cnt_reg  <= '0;
            file_size_reg <= '0;
            err_reg       <= 1'b0;
            cmplt_reg     <= 1'b0;
        end else begin
            err_reg   <= res_drop;
            cmplt_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_id_reg  <= pick_id;
                        mode_proc_reg <= pick_mode_proc;
                        byte_cnt_reg  <= '0;
                        file_size_reg <= '0;
                        state_reg     <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (accept) begin
                        byte_cnt_reg  <= byte_sum[31:0];
                        file_size_reg <= fs_next;
                        if (byte_sum >= HDR_S) begin
                            if (fs_next <= HDR_C) begin
                                err_reg   <= 1'b1;
                                state_reg <= ST_FLUSH;
                            end else begin
                                state_reg <= ST_BODY;
                            end
                        end
                    end else if (stall_hit) begin
                        err_reg   <= 1'b1;
                        state_reg <= ST_FLUSH;
                    end
                end
                ST_BODY: begin
                    if (accept) begin
                        byte_cnt_reg <= byte_sum[31:0];
                        if (byte_sum >= {1'b0, file_size_reg})
                            state_reg <= ST_FLUSH;
                    end else if (stall_hit) begin
                        err_reg   <= 1'b1;
                        state_reg <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (outstanding_reg == '0 && fifo_empty) begin
                        cmplt_reg  <= 1'b1;
                        rr_ptr_reg <= (grant_id_reg == LAST_ID) ? '0 : grant_id_reg + GW'(1);
                        state_reg  <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            outstanding_reg <= '0;
        else if (issue && !(res_ok && outstanding_reg != '0))
            outstanding_reg <= outstanding_reg + CW'(1);
        else if (!issue && res_ok && outstanding_reg != '0)
            outstanding_reg <= outstanding_reg - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            fifo_mem[wr_ptr_reg] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
            if (push_ok && !pop)
                fifo_count_reg <= fifo_count_reg + CW'(1);
            else if (!push_ok && pop)
                fifo_count_reg <= fifo_count_reg - CW'(1);
        end
    end

    assign mstr_valid = !fifo_empty;
    assign mstr_data  = fifo_empty ? '0 : fifo_mem[rd_ptr_reg];
    assign mstr_cmplt = cmplt_reg;
    assign grant_id   = grant_id_reg;
    assign file_size  = file_size_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_bmp_stream_sched.sv
// Randomized scoreboard bench for bmp_stream_sched (32-bit bus, 2 slaves, depth-8 FIFO);
// defines SCHED_TIMEOUT_EN to also run the stall-timeout scenario.
module tb_bmp_stream_sched;

    localparam logic [31:0] KEY = 32'h5A5A_0F0F;
    localparam int HDR_WORDS = 14;

    logic        clk, rst_n;
    logic [1:0]  slv_valid, slv_ready;
    logic [3:0]  slv_mode;
    logic [63:0] slv_data;
    logic [31:0] proc_data, proc_res_data, mstr_data, file_size;
    logic        proc_vld, proc_rdy, proc_res_vld, mstr_ready, mstr_valid, mstr_cmplt, err;
    logic [0:0]  grant_id;

    bmp_stream_sched #(.DATA_BUS_SIZE(32), .NUM_SLV(2), .FIFO_DEPTH(8),
                       .HDR_BYTES(56), .TIMEOUT_CYCLES(1024)) dut (
        .clk(clk), .rst_n(rst_n), .slv_valid(slv_valid), .slv_mode(slv_mode),
        .slv_data(slv_data), .slv_ready(slv_ready), .proc_data(proc_data),
        .proc_vld(proc_vld), .proc_rdy(proc_rdy), .proc_res_data(proc_res_data),
        .proc_res_vld(proc_res_vld), .mstr_ready(mstr_ready), .mstr_data(mstr_data),
        .mstr_valid(mstr_valid), .mstr_cmplt(mstr_cmplt), .grant_id(grant_id),
        .file_size(file_size), .err(err));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; int tag; } exp_t;
    typedef struct { int tag; int gid; logic [31:0] fsize; } cmp_t;
    typedef struct { logic [31:0] data; int due; } res_t;

    exp_t        exp_q[$];
    cmp_t        cmp_q[$];
    res_t        pipe[$];
    logic [31:0] sq[2][$];
    logic [1:0]  smode[2];
    int          sent[2];

    int n_vec = 0, fails = 0, err_seen = 0, err_exp = 0;
    int occ = 0, outst = 0, max_sum = 0, iss_cnt = 0, cyc = 0;
    int inject_req = 0, inject_done = 0, rr_model = 0, tag_n = 0;
    bit rdy_hold = 0, bp_hold = 0, res_legit = 0;

    // Build one file on slave s: header carries fsize in bytes 2..5 little-endian
    task automatic load_file(input int s, input logic [1:0] mode, input int fsize, input int nwords);
        logic [31:0] w, fsv;
        exp_t e;
        fsv = 32'(fsize);
        for (int i = 0; i < nwords; i++) begin
            w = $urandom;
            for (int k = 0; k < 4; k++) begin
                if (i*4 + k >= 2 && i*4 + k <= 5) w[8*k +: 8] = fsv[8*(i*4 + k - 2) +: 8];
            end
            sq[s].push_back(w);
            e.tag  = tag_n;
            e.data = (i >= HDR_WORDS && mode == 2'b01) ? (w ^ KEY) : w;
            exp_q.push_back(e);
        end
        cmp_q.push_back('{tag_n, s, fsv});
        sent[s]  = 0;
        smode[s] = mode;
        tag_n++;
    endtask

    task automatic wait_done(input int limit, input string name);
        int c = 0;
        while ((exp_q.size() != 0 || cmp_q.size() != 0) && c < limit) begin
            @(posedge clk);
            c++;
        end
        if (c >= limit) begin
            n_vec++; fails++;
            $display("FAIL %s: timeout with %0d words and %0d completions pending, required 0",
                     name, exp_q.size(), cmp_q.size());
            exp_q.delete();
            cmp_q.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_sent(input int s, input int n);
        int c = 0;
        while (sent[s] < n && c < 4000) begin
            @(posedge clk);
            c++;
        end
    endtask

    task automatic check_zero(input string name);
        n_vec++;
        if ({slv_ready, proc_vld, proc_data, mstr_valid, mstr_cmplt, file_size, err} != '0) begin
            fails++;
            $display("FAIL %s: outputs=%h required 0", name,
                     {slv_ready, proc_vld, proc_data, mstr_valid, mstr_cmplt, file_size, err});
        end
    endtask

    // Stimulus driver: slaves, processor model and master ready, updated 1 time unit after each edge
    initial begin
        bit hs[2];
        bit iss;
        logic [31:0] idata;
        slv_valid = '0; slv_mode = '0; slv_data = '0; proc_rdy = 1'b0;
        proc_res_vld = 1'b0; proc_res_data = '0; mstr_ready = 1'b0;
        forever begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) hs[s] = slv_valid[s] && slv_ready[s];
            iss   = proc_vld && proc_rdy;
            idata = proc_data;
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) pipe.delete();
            for (int s = 0; s < 2; s++) begin
                if (hs[s] && sq[s].size() > 0) begin
                    void'(sq[s].pop_front());
                    sent[s]++;
                end
                slv_valid[s] = sq[s].size() > 0 && (sent[s] == 0 || $urandom_range(7) != 0);
                slv_data[s*32 +: 32] = (sq[s].size() > 0) ? sq[s][0] : $urandom;
                slv_mode[2*s +: 2]   = (sent[s] > 0) ? 2'($urandom_range(3)) : smode[s];
            end
            if (iss && rst_n) pipe.push_back('{idata ^ KEY, cyc + 3});
            if (pipe.size() > 0 && pipe[0].due <= cyc) begin
                proc_res_vld = 1'b1; proc_res_data = pipe[0].data; res_legit = 1'b1;
                void'(pipe.pop_front());
            end else if (inject_req != inject_done) begin
                proc_res_vld = 1'b1; proc_res_data = $urandom; res_legit = 1'b0;
                inject_done++;
            end else begin
                proc_res_vld = 1'b0; res_legit = 1'b0;
            end
            proc_rdy   = rdy_hold ? 1'b1 : ($urandom_range(3) != 0);
            mstr_ready = bp_hold ? 1'b0 : ($urandom_range(3) != 0);
        end
    end

    // Monitor: scoreboard pops on master handshakes and completion pulses
    always @(negedge clk) begin
        if (!rst_n) begin
            occ = 0;
            outst = 0;
        end else begin
            if (mstr_valid && mstr_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL word: got %h with nothing outstanding", mstr_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (mstr_data !== e.data) begin
                        fails++;
                        $display("FAIL word(file %0d): got %h required %h", e.tag, mstr_data, e.data);
                    end
                end
                occ--;
            end
            if (slv_valid & slv_ready) begin
                if (!(proc_vld && proc_rdy)) occ++;
            end
            if (proc_vld && proc_rdy) begin
                outst++;
                iss_cnt++;
            end
            if (proc_res_vld && res_legit) begin
                outst--;
                occ++;
            end
            if (occ + outst > max_sum) max_sum = occ + outst;
            if (err) err_seen++;
            if (mstr_cmplt) begin
                n_vec++;
                if (cmp_q.size() == 0) begin
                    fails++;
                    $display("FAIL cmplt: spurious pulse, grant_id=%0d", grant_id);
                end else begin
                    cmp_t r;
                    r = cmp_q.pop_front();
                    if (int'(grant_id) != r.gid || file_size !== r.fsize ||
                        (exp_q.size() != 0 && exp_q[0].tag == r.tag)) begin
                        fails++;
                        $display("FAIL cmplt(file %0d): grant_id=%0d file_size=%0d required %0d/%0d, words left %0d",
                                 r.tag, grant_id, file_size, r.gid, r.fsize, exp_q.size());
                    end else begin
                        $display("file %0d done: slave %0d, %0d bytes", r.tag, r.gid, r.fsize);
                    end
                end
            end
        end
    end

    initial begin
        int s, sz, iss0;
        logic [1:0] m;
        rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #2 check_zero("reset_outputs");
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Bypass file on slave 0, 118 bytes
        rdy_hold = 1;
        load_file(0, 2'b10, 118, 30);
        wait_done(3000, "bypass_file");
        rr_model = 1;

        // Process file on slave 1, 118 bytes, processor always ready
        iss0 = iss_cnt;
        load_file(1, 2'b01, 118, 30);
        wait_done(3000, "process_file");
        n_vec++;
        if (iss_cnt - iss0 != 16) begin
            fails++;
            $display("FAIL proc_beats: got %0d required 16", iss_cnt - iss0);
        end
        rr_model = 0;
        rdy_hold = 0;

        // Both slaves requesting: slave 0 first, then slave 1
        load_file(0, 2'b01, 57 + $urandom_range(150), 0);
        sz = int'(cmp_q[0].fsize);
        exp_q.delete(); cmp_q.delete(); sq[0].delete(); tag_n--;
        load_file(0, 2'b01, sz, (sz + 3) / 4);
        sz = 57 + $urandom_range(150);
        load_file(1, 2'b01, sz, (sz + 3) / 4);
        wait_done(6000, "arbitration");
        rr_model = 0;

        // Randomized files
        for (int t = 0; t < 6; t++) begin
            s  = $urandom_range(1);
            m  = $urandom_range(1) ? 2'b01 : 2'b10;
            sz = 57 + $urandom_range(343);
            load_file(s, m, sz, (sz + 3) / 4);
            wait_done(6000, "random_file");
            rr_model = (s + 1) % 2;
        end

        // Master backpressure for 40 cycles during body
        s = rr_model;
        load_file(s, 2'b01, 400, 100);
        wait_sent(s, 20);
        bp_hold = 1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (slv_ready != 2'b00) begin
            fails++;
            $display("FAIL backpressure_ready: slv_ready=%b required 00", slv_ready);
        end
        bp_hold = 0;
        wait_done(6000, "backpressure");
        rr_model = (s + 1) % 2;

        // Header-only files with file_size at or below the header length
        load_file(rr_model, 2'b10, 40, HDR_WORDS);
        err_exp++;
        wait_done(3000, "size_40");
        rr_model = (rr_model + 1) % 2;
        load_file(rr_model, 2'b01, 56, HDR_WORDS);
        err_exp++;
        wait_done(3000, "size_56");
        rr_model = (rr_model + 1) % 2;
        load_file(rr_model, 2'b01, 57, 15);
        wait_done(3000, "size_57");
        rr_model = (rr_model + 1) % 2;

        // Stray processor result while idle
        inject_req++;
        err_exp++;
        repeat (6) @(posedge clk);

        // Reset in the middle of a process-mode body
        load_file(rr_model, 2'b01, 400, 100);
        wait_sent(rr_model, 20);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_zero("reset_mid_body");
        sq[0].delete(); sq[1].delete(); exp_q.delete(); cmp_q.delete();
        repeat (5) @(posedge clk);
        sq[0].delete(); sq[1].delete();
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        load_file(1, 2'b10, 120, 30);
        wait_done(3000, "after_reset");
        rr_model = 0;

`ifdef SCHED_TIMEOUT_EN
        load_file(0, 2'b10, 400, 20);
        err_exp++;
        wait_done(4000, "stall_timeout");
        rr_model = 1;
`endif

        n_vec++;
        if (err_seen != err_exp) begin
            fails++;
            $display("FAIL err_pulses: got %0d required %0d", err_seen, err_exp);
        end
        n_vec++;
        if (max_sum > 8) begin
            fails++;
            $display("FAIL credit_bound: fifo+outstanding reached %0d required <= 8", max_sum);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, fails);
        $finish;
    end

endmodule
